jbi_min_sctag_arb: RTL and testbench
====================================

// Module: jbi_min_sctag_arb
// PURPOSE
//  Issue arbiter that shares the single JBI->SCTAG request path among the four
//  per-sctag request queue pairs (rhq0-3 headers, rdq0-3 write data).
//  Grants one queue at a time, round-robin, gated by per-sctag credits.
//  Sequences each grant as a header pop, plus WR_BEATS data pops for writes.
//  Sits in jbi_min downstream of the write decomposition queue (wdq).
// PARAMETERS
//  CREDITS   4  initial/max outstanding requests per sctag (1..7)
//  WR_BEATS  2  data beats following a write header (1..4)
// PORTS
//  clk             in   1  JBI clock
//  arst_l          in   1  asynchronous active-low reset
//  arb_en          in   1  csr enable; 0 blocks new grants
//  rhq_vld         in   4  rhq[i] not empty (head request present)
//  rhq_wr          in   4  rhq[i] head is a write (valid only with rhq_vld[i])
//  sctag_cred_ret  in   4  one-cycle pulse: sctag[i] returns one credit
//  arb_rhq_pop     out  4  one-hot pop of rhq head (header issue cycle)
//  arb_rdq_pop     out  4  one-hot pop of rdq data beat
//  arb_hdr_vld     out  1  header on SCTAG path this cycle
//  arb_data_vld    out  1  write data beat on SCTAG path this cycle
//  arb_sel         out  2  index of sctag being issued (valid with hdr/data vld)
//  arb_busy        out  1  transaction in flight (state != IDLE)
//  arb_cred_err    out  4  sticky: credit returned while counter at CREDITS
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr_ptr=3 (so sctag0 wins first);
//   cred[i]=CREDITS; beat counter 0. Reset mid-transaction abandons it.
//  All outputs registered; the grant decision in cycle N drives hdr in N+1.
//  State machine: IDLE, HDR, DATA.
//   - slot_free = IDLE | (HDR & ~cur_wr) | (DATA & last_beat).
//   - elig[i] = arb_en & rhq_vld[i] & (cred[i]!=0).
//   - slot_free & |elig: pick first elig at rr_ptr+1, +2, +3, +4 (mod 4).
//     Next state HDR; cur_sel and cur_wr are latched; rr_ptr<=winner;
//     cred[winner] decrements.
//   - slot_free & ~|elig: go to IDLE.
//   - HDR & cur_wr: go to DATA with beat=0. In DATA, beat++ each cycle.
//     Leave DATA after beat==WR_BEATS-1.
//  In HDR: arb_hdr_vld=1, arb_rhq_pop[cur_sel]=1, arb_sel=cur_sel.
//  In DATA: arb_data_vld=1, arb_rdq_pop[cur_sel]=1, arb_sel=cur_sel.
//  Throughput: back-to-back reads issue one header per cycle.
//   Write costs 1+WR_BEATS cycles. No idle bubble between transactions.
//  Credits: 3-bit saturating counters.
//   - Grant and return on the same sctag in the same cycle: net unchanged.
//   - Return at CREDITS without a same-cycle grant: count held and
//     arb_cred_err[i] set. The error bit clears only on reset.
//  arb_en falling mid-write: current transaction completes and no new grant
//   is made. rhq_vld dropping for a granted queue does not cancel the grant.
//   Producer guarantees head stability until the pop.
//  rhq_wr is sampled only at the grant cycle.
//  Never more than one bit set across arb_rhq_pop|arb_rdq_pop in any cycle.
// TESTING
//  1. Reset, then rhq_vld=4'b1111, all reads -> hdr to sel 0,1,2,3,0,...
//     every cycle. Each cred hits 0 after 4 grants, then grants stop.
//  2. rhq_vld=4'b0101, rhq_wr=4'b0001, WR_BEATS=2 -> hdr0, data0, data0,
//     hdr2, hdr0. Pops one-hot, no gap cycles.
//  3. cred[1]=0 with only rhq1 valid -> no grant. A sctag_cred_ret[1] pulse
//     gives a grant the next cycle and hdr1 the cycle after.
//  4. Grant to 2 while sctag_cred_ret[2]=1 in the same cycle -> cred[2]
//     unchanged. A return at CREDITS sets arb_cred_err[2] and it stays set.
//  5. arb_en cleared during DATA beat 0 -> both beats complete, then IDLE,
//     arb_busy=0, no further pops.
//  6. arst_l asserted in DATA -> outputs 0 asynchronously and cred=CREDITS.
//     After release the first grant goes to sctag0.

Source files
------------

// File: rtl/jbi_min_sctag_arb_if.sv
// Request-path bundle between the rhq/rdq queue pairs, the sctag credit returns
// and the JBI->SCTAG issue arbiter.
interface jbi_min_sctag_arb_if;
  logic       arb_en;
  logic [3:0] rhq_vld;
  logic [3:0] rhq_wr;
  logic [3:0] sctag_cred_ret;
  logic [3:0] arb_rhq_pop;
  logic [3:0] arb_rdq_pop;
  logic       arb_hdr_vld;
  logic       arb_data_vld;
  logic [1:0] arb_sel;
  logic       arb_busy;
  logic [3:0] arb_cred_err;

  modport master (
    output arb_en, rhq_vld, rhq_wr, sctag_cred_ret,
    input  arb_rhq_pop, arb_rdq_pop, arb_hdr_vld, arb_data_vld,
           arb_sel, arb_busy, arb_cred_err
  );

  modport slave (
    input  arb_en, rhq_vld, rhq_wr, sctag_cred_ret,
    output arb_rhq_pop, arb_rdq_pop, arb_hdr_vld, arb_data_vld,
           arb_sel, arb_busy, arb_cred_err
  );
endinterface

// File: rtl/jbi_min_sctag_arb.sv
// Round-robin, credit-gated issue arbiter sharing the JBI->SCTAG request path
// among four rhq/rdq queue pairs; writes carry WR_BEATS data beats after the header.

// Per-sctag saturating credit counter with sticky over-return error.
module jbi_min_sctag_arb_cred #(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic arst_l,
  input  logic grant_i,
  input  logic ret_i,
  output logic nz_o,
  output logic err_o
);
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (grant_i && !ret_i) begin
      cnt_d = cnt_q - 3'd1;
    end else if (ret_i && !grant_i) begin
      // A return with the pool already full is a protocol error: hold, flag.
      if (cnt_q == CRED_MAX) err_d = 1'b1;
      else                   cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      cnt_q <= CRED_MAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign nz_o  = |cnt_q;
  assign err_o = err_q;
endmodule

module jbi_min_sctag_arb #(
  parameter int CREDITS  = 4,
  parameter int WR_BEATS = 2
) (
  input  logic                 clk,
  input  logic                 arst_l,
  jbi_min_sctag_arb_if.slave   arb
);
  localparam int         NUM_Q     = 4;
  localparam logic [1:0] BEAT_LAST = 2'(WR_BEATS - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t     state_q, state_d;
  logic [1:0] cur_sel_q, cur_sel_d;
  logic       cur_wr_q, cur_wr_d;
  logic [1:0] beat_q, beat_d;
  logic [1:0] rr_q, rr_d;

  logic             hdr_q, dat_q, busy_q;
  logic [1:0]       sel_q;
  logic [NUM_Q-1:0] rpop_q, dpop_q;

  logic             hdr_d, dat_d, busy_d;
  logic [1:0]       sel_d;
  logic [NUM_Q-1:0] rpop_d, dpop_d;

  logic [NUM_Q-1:0] cred_nz, cred_err, elig, grant, cred_ret;
  logic [1:0]       win;
  logic             any_elig, slot_free, last_beat;

  assign cred_ret = arb.sctag_cred_ret;

  jbi_min_sctag_arb_cred #(.CREDITS(CREDITS)) u_cred [NUM_Q-1:0] (
    .clk     (clk),
    .arst_l  (arst_l),
    .grant_i (grant),
    .ret_i   (cred_ret),
    .nz_o    (cred_nz),
    .err_o   (cred_err)
  );

  assign elig      = {NUM_Q{arb.arb_en}} & arb.rhq_vld & cred_nz;
  assign any_elig  = |elig;
  assign last_beat = (beat_q == BEAT_LAST);
  // The path frees in the cycle the last piece of the current transaction issues,
  // so the next grant lands with no bubble.
  assign slot_free = (state_q == IDLE) || (state_q == HDR && !cur_wr_q) ||
                     (state_q == DATA && last_beat);

  // Search starts one past the last winner and wraps back to it last.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    win   = rr_q;
    found = 1'b0;
    idx   = rr_q;
    for (int k = 1; k <= NUM_Q; k++) begin
      idx = rr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant = (slot_free && any_elig) ? (NUM_Q'(1) << win) : '0;

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    cur_wr_d  = cur_wr_q;
    beat_d    = beat_q;
    rr_d      = rr_q;
    case (state_q)
      HDR:     if (cur_wr_q) begin
                 state_d = DATA;
                 beat_d  = 2'd0;
               end
      DATA:    if (!last_beat) beat_d = beat_q + 2'd1;
      default: ;
    endcase
    if (slot_free) begin
      if (any_elig) begin
        state_d   = HDR;
        cur_sel_d = win;
        cur_wr_d  = arb.rhq_wr[win];
        rr_d      = win;
      end else begin
        state_d   = IDLE;
      end
    end
  end

  // Outputs are decoded from next state so they come straight off flops.
  always_comb begin
    hdr_d  = (state_d == HDR);
    dat_d  = (state_d == DATA);
    busy_d = (state_d != IDLE);
    sel_d  = (hdr_d || dat_d) ? cur_sel_d : 2'd0;
    rpop_d = hdr_d ? (NUM_Q'(1) << cur_sel_d) : '0;
    dpop_d = dat_d ? (NUM_Q'(1) << cur_sel_d) : '0;
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q   <= IDLE;
      cur_sel_q <= 2'd0;
      cur_wr_q  <= 1'b0;
      beat_q    <= 2'd0;
      rr_q      <= 2'd3;
      hdr_q     <= 1'b0;
      dat_q     <= 1'b0;
      busy_q    <= 1'b0;
      sel_q     <= 2'd0;
      rpop_q    <= '0;
      dpop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      cur_wr_q  <= cur_wr_d;
      beat_q    <= beat_d;
      rr_q      <= rr_d;
      hdr_q     <= hdr_d;
      dat_q     <= dat_d;
      busy_q    <= busy_d;
      sel_q     <= sel_d;
      rpop_q    <= rpop_d;
      dpop_q    <= dpop_d;
    end
  end

  assign arb.arb_hdr_vld  = hdr_q;
  assign arb.arb_data_vld = dat_q;
  assign arb.arb_busy     = busy_q;
  assign arb.arb_sel      = sel_q;
  assign arb.arb_rhq_pop  = rpop_q;
  assign arb.arb_rdq_pop  = dpop_q;
  assign arb.arb_cred_err = cred_err;
endmodule

// File: tb/tb_jbi_min_sctag_arb.sv
// Directed bench for jbi_min_sctag_arb: CREDITS=4, WR_BEATS=2. Inputs are driven
// and outputs sampled on the falling edge.
module tb_jbi_min_sctag_arb;
  logic clk;
  logic arst_l;
  int   checks;
  int   failures;

  jbi_min_sctag_arb_if bus ();

  jbi_min_sctag_arb #(.CREDITS(4), .WR_BEATS(2)) dut (
    .clk    (clk),
    .arst_l (arst_l),
    .arb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic eh, input logic ed,
                     input logic [3:0] erp, input logic [3:0] edp,
                     input logic [1:0] es, input logic eb);
    logic [12:0] o, e;
    // arb_sel only carries meaning alongside hdr/data valid
    e = {eh, ed, erp, edp, (eh | ed) ? es : 2'b00, eb};
    o = {bus.arb_hdr_vld, bus.arb_data_vld, bus.arb_rhq_pop, bus.arb_rdq_pop,
         (eh | ed) ? bus.arb_sel : 2'b00, bus.arb_busy};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (hdr,dat,rpop,dpop,sel,busy)", tag, o, e);
    end
  endtask

  task automatic exp_hdr(input string tag, input int s);
    chk(tag, 1'b1, 1'b0, 4'(1 << s), 4'b0000, 2'(s), 1'b1);
  endtask

  task automatic exp_dat(input string tag, input int s);
    chk(tag, 1'b0, 1'b1, 4'b0000, 4'(1 << s), 2'(s), 1'b1);
  endtask

  task automatic exp_idle(input string tag);
    chk(tag, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
  endtask

  task automatic exp_err(input string tag, input logic [3:0] e);
    checks++;
    assert (bus.arb_cred_err === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, bus.arb_cred_err, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    arst_l   = 1'b0;
    bus.arb_en         = 1'b0;
    bus.rhq_vld        = 4'b0000;
    bus.rhq_wr         = 4'b0000;
    bus.sctag_cred_ret = 4'b0000;

    // Reset state
    repeat (2) @(negedge clk);
    exp_idle("reset_outputs");
    exp_err("reset_err", 4'b0000);
    arst_l = 1'b1;
    @(negedge clk);
    exp_idle("post_reset_idle");

    // 1: all four reading, round-robin 0..3 until each has spent 4 credits
    bus.arb_en  = 1'b1;
    bus.rhq_vld = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_hdr($sformatf("t1_rr_%0d", i), i % 4);
    end
    @(negedge clk);
    exp_idle("t1_creds_exhausted");

    // 3: only rhq1 valid with zero credits, then one credit returned
    bus.rhq_vld = 4'b0010;
    @(negedge clk);
    exp_idle("t3_no_cred");
    bus.sctag_cred_ret = 4'b0010;
    @(negedge clk);
    exp_idle("t3_ret_cycle");
    bus.sctag_cred_ret = 4'b0000;
    @(negedge clk);
    exp_hdr("t3_hdr1", 1);
    @(negedge clk);
    exp_idle("t3_cred_spent");
    bus.rhq_vld = 4'b0000;

    // 2: fresh reset, write on 0 then read on 2 then write on 0, no gaps
    arst_l = 1'b0;
    @(negedge clk);
    arst_l = 1'b1;
    bus.rhq_vld = 4'b0101;
    bus.rhq_wr  = 4'b0001;
    @(negedge clk); exp_hdr("t2_hdr0", 0);
    @(negedge clk); exp_dat("t2_dat0_b0", 0);
    @(negedge clk); exp_dat("t2_dat0_b1", 0);
    @(negedge clk); exp_hdr("t2_hdr2", 2);
    @(negedge clk); exp_hdr("t2_hdr0_again", 0);
    bus.rhq_vld = 4'b0000;
    @(negedge clk); exp_dat("t2_dat0_again_b0", 0);
    @(negedge clk); exp_dat("t2_dat0_again_b1", 0);
    @(negedge clk); exp_idle("t2_idle");
    bus.rhq_wr = 4'b0000;

    // 4: cred[2]=3; grant with same-cycle return keeps it at 3,
    // so one return fills it and the next one is an error
    bus.rhq_vld        = 4'b0100;
    bus.sctag_cred_ret = 4'b0100;
    @(negedge clk); exp_hdr("t4_hdr2", 2);
    bus.rhq_vld        = 4'b0000;
    bus.sctag_cred_ret = 4'b0000;
    @(negedge clk); exp_idle("t4_idle");
    exp_err("t4_err_clear", 4'b0000);
    bus.sctag_cred_ret = 4'b0100;
    @(negedge clk); exp_err("t4_fill_no_err", 4'b0000);
    @(negedge clk); exp_err("t4_over_return", 4'b0100);
    bus.sctag_cred_ret = 4'b0000;
    repeat (2) @(negedge clk);
    exp_err("t4_err_sticky", 4'b0100);

    // 5: arb_en drops during DATA beat 0, write still completes
    bus.rhq_vld = 4'b0001;
    bus.rhq_wr  = 4'b0001;
    @(negedge clk); exp_hdr("t5_hdr0", 0);
    @(negedge clk); exp_dat("t5_dat_b0", 0);
    bus.arb_en = 1'b0;
    @(negedge clk); exp_dat("t5_dat_b1", 0);
    @(negedge clk); exp_idle("t5_idle");
    @(negedge clk); exp_idle("t5_stays_idle");

    // 6: reset in DATA; cred0 is 0 beforehand, so sctag0 winning first
    // afterwards shows credits were restored
    bus.arb_en = 1'b1;
    @(negedge clk); exp_hdr("t6_hdr0", 0);
    @(negedge clk); exp_dat("t6_dat_b0", 0);
    #2 arst_l = 1'b0;
    #1 exp_idle("t6_async_reset");
    exp_err("t6_err_reset", 4'b0000);
    bus.rhq_vld = 4'b1111;
    bus.rhq_wr  = 4'b0000;
    @(negedge clk);
    arst_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_hdr($sformatf("t6_rr_%0d", i), i);
    end
    bus.rhq_vld = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
